// File: rtl/vq_sched_pkg.sv
// Shared types and default sizes for the vending order queue scheduler.
package vq_sched_pkg;
  localparam int DEPTH_DEF = 10;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_PRESENT
  } rd_state_e;

  typedef enum logic {
    TURN_WR,
    TURN_RD
  } turn_e;
endpackage

// File: rtl/vend_queue_sched_if.sv
// Station, FIFO and dispenser signals of the scheduler; master is the scheduler side.
interface vend_queue_sched_if
  import vq_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEF,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic               fifo_rd;
  logic [DW-1:0]      fifo_dout;
  logic               disp_valid;
  logic [DW-1:0]      disp_data;
  logic               disp_ready;
  logic [CW-1:0]      count;

  modport master (
    input  req, req_data, fifo_dout, disp_ready,
    output gnt, fifo_wr, fifo_din, fifo_rd, disp_valid, disp_data, count
  );

  modport slave (
    output req, req_data, fifo_dout, disp_ready,
    input  gnt, fifo_wr, fifo_din, fifo_rd, disp_valid, disp_data, count
  );
endinterface

// File: rtl/vend_queue_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_vld
);
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      w_idx = w_sum[PW-1:0];
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vend_queue_sched.sv
// Round-robin station scheduler and read sequencer for the vending order FIFO.
// Optional VQ_SCHED_WATERMARK_EN throttles station writes at HI_WM entries.
module vend_queue_sched
  import vq_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int HI_WM = 8
) (
  input logic                clk,
  input logic                rst,
  vend_queue_sched_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef VQ_SCHED_WATERMARK_EN
  localparam int WR_LIMIT = (HI_WM < DEPTH) ? HI_WM : DEPTH;
`else
  localparam int WR_LIMIT = DEPTH;
`endif

  if (HI_WM < 1 || HI_WM > DEPTH) begin : g_bad_wm
    $error("vend_queue_sched: HI_WM must lie in 1..DEPTH");
  end

  logic [NREQ-1:0] r_gnt, w_req_m, w_arb_gnt;
  logic            w_arb_vld;
  logic [PW-1:0]   r_ptr, w_gnt_idx, w_ptr_nxt;
  logic [DW-1:0]   r_fifo_din, w_sel_dat, r_disp_data;
  logic            r_fifo_wr;
  logic [CW-1:0]   r_count;
  turn_e           r_turn;
  rd_state_e       r_state, w_state_nxt;
  logic            w_wr_cand, w_rd_cand, w_wr_win, w_rd_win;
  logic            w_fifo_rd, w_disp_valid;

  // A station is still holding req during its own gnt cycle, so mask it out.
  assign w_req_m = bus.req & ~r_gnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (w_req_m),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_vld (w_arb_vld)
  );

  always_comb begin
    w_gnt_idx = '0;
    w_sel_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_gnt_idx = PW'(i);
        w_sel_dat = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_wr_cand = w_arb_vld && (r_count < CW'(WR_LIMIT));
  assign w_rd_cand = (r_state == RD_IDLE) && (r_count != '0);
  assign w_wr_win  = w_wr_cand && (!w_rd_cand || r_turn == TURN_WR);
  assign w_rd_win  = w_rd_cand && (!w_wr_cand || r_turn == TURN_RD);

  // count moves on the decision edge so the next decision already sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= '0;
      r_fifo_wr  <= 1'b0;
      r_fifo_din <= '0;
      r_ptr      <= '0;
      r_count    <= '0;
      r_turn     <= TURN_WR;
    end else begin
      r_gnt     <= w_wr_win ? w_arb_gnt : '0;
      r_fifo_wr <= w_wr_win;
      if (w_wr_win) begin
        r_fifo_din <= w_sel_dat;
        r_ptr      <= w_ptr_nxt;
      end
      if (w_wr_win)      r_count <= r_count + 1'b1;
      else if (w_rd_win) r_count <= r_count - 1'b1;
      if (w_wr_cand && w_rd_cand) r_turn <= (r_turn == TURN_WR) ? TURN_RD : TURN_WR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RD_IDLE:    if (w_rd_win) w_state_nxt = RD_ISSUE;
      RD_ISSUE:   w_state_nxt = RD_WAIT;
      RD_WAIT:    w_state_nxt = RD_PRESENT;
      RD_PRESENT: if (bus.disp_ready) w_state_nxt = RD_IDLE;
      default:    w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_fifo_rd    = (r_state == RD_ISSUE);
    w_disp_valid = (r_state == RD_PRESENT);
  end

  // FIFO presents its read word in the cycle after fifo_rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_disp_data <= '0;
    else if (r_state == RD_WAIT) r_disp_data <= bus.fifo_dout;
  end

  assign bus.gnt        = r_gnt;
  assign bus.fifo_wr    = r_fifo_wr;
  assign bus.fifo_din   = r_fifo_din;
  assign bus.fifo_rd    = w_fifo_rd;
  assign bus.disp_valid = w_disp_valid;
  assign bus.disp_data  = r_disp_data;
  assign bus.count      = r_count;

  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
endmodule
